csr_counter_bank: RTL and testbench

//  Bank of NUM_CNT event counters, each CNT_WIDTH bits wide, for cycle, instret and hpm-style CSRs.

---
 rtl/csr_counter_bank.sv | 146 ++++++++++++++
 tb/tb_csr_counter_bank.sv | 387 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/csr_counter_bank.sv
// csr_counter_bank: bank of NUM_CNT event counters (cycle/instret/hpm style).
// Each counter is read and modified through the CSR port as two XLEN-bit
// halves, using write / set / clear ops that mirror CSRRW / CSRRS / CSRRC.
// Optional build macro CSR_CNT_OVF_EN adds sticky per-counter wrap flags
// (ovf_o), their clear strobes (ovf_clr_i) and an OR-reduced interrupt
// (ovf_irq_o). With the macro undefined, none of that logic or those ports exist.
module csr_counter_bank #(
    parameter int unsigned NUM_CNT   = 4,
    parameter int unsigned XLEN      = 32,
    parameter int unsigned CNT_WIDTH = 64,
    parameter logic [CNT_WIDTH-1:0] RESET_VALUE = '0,
    localparam int unsigned SEL_W    = (NUM_CNT > 1) ? $clog2(NUM_CNT) : 1
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               csr_en_i,
    input  logic [1:0]         csr_op_i,
    input  logic [SEL_W-1:0]   csr_sel_i,
    input  logic               csr_hi_i,
    input  logic [XLEN-1:0]    csr_wdata_i,
    input  logic [NUM_CNT-1:0] inc_i,
    input  logic [NUM_CNT-1:0] inhibit_i,
`ifdef CSR_CNT_OVF_EN
    input  logic [NUM_CNT-1:0] ovf_clr_i,
    output logic [NUM_CNT-1:0] ovf_o,
    output logic               ovf_irq_o,
`endif
    output logic [XLEN-1:0]    csr_rdata_o
);

    // Bits held by the upper half; may be narrower than XLEN.
    localparam int unsigned HI_W = CNT_WIDTH - XLEN;

    localparam logic [1:0] OP_WRITE = 2'b01;
    localparam logic [1:0] OP_SET   = 2'b10;
    localparam logic [1:0] OP_CLEAR = 2'b11;

    logic [CNT_WIDTH-1:0] cnt_q [NUM_CNT];
    logic [CNT_WIDTH-1:0] cnt_d [NUM_CNT];

    logic                 sel_valid;
    logic [CNT_WIDTH-1:0] sel_cnt;
    logic [XLEN-1:0]      sel_half;
    logic [XLEN-1:0]      mod_half;
    logic [CNT_WIDTH-1:0] mod_cnt;
    logic                 mod_valid;
    logic [NUM_CNT-1:0]   mod_hit;

    // Fetch the selected counter; out-of-range indices read as zero.
    always_comb begin
        sel_valid = (32'(csr_sel_i) < NUM_CNT);
        sel_cnt   = '0;
        if (sel_valid) begin
            sel_cnt = cnt_q[csr_sel_i];
        end
    end

    // Pick the addressed half; the upper half is zero-extended to XLEN.
    always_comb begin
        if (csr_hi_i) begin
            sel_half = XLEN'(sel_cnt[CNT_WIDTH-1:XLEN]);
        end else begin
            sel_half = sel_cnt[XLEN-1:0];
        end
    end

    assign csr_rdata_o = sel_half;

    // Apply the CSR op to the selected half; the other half passes through untouched.
    always_comb begin
        mod_half = sel_half;
        case (csr_op_i)
            OP_WRITE: mod_half = csr_wdata_i;
            OP_SET:   mod_half = sel_half | csr_wdata_i;
            OP_CLEAR: mod_half = sel_half & ~csr_wdata_i;
            default:  mod_half = sel_half;
        endcase
        mod_cnt = sel_cnt;
        if (csr_hi_i) begin
            mod_cnt[CNT_WIDTH-1:XLEN] = mod_half[HI_W-1:0];
        end else begin
            mod_cnt[XLEN-1:0] = mod_half;
        end
    end

    assign mod_valid = csr_en_i && (csr_op_i != 2'b00) && sel_valid;

    // One-hot target of the modify, used to suppress that counter's increment.
    always_comb begin
        mod_hit = '0;
        for (int i = 0; i < NUM_CNT; i++) begin
            mod_hit[i] = mod_valid && (csr_sel_i == SEL_W'(i));
        end
    end

    // Next value per counter: a software modify takes priority over the event.
    always_comb begin
        for (int i = 0; i < NUM_CNT; i++) begin
            cnt_d[i] = cnt_q[i];
            if (mod_hit[i]) begin
                cnt_d[i] = mod_cnt;
            end else if (inc_i[i] && !inhibit_i[i]) begin
                cnt_d[i] = cnt_q[i] + CNT_WIDTH'(1);
            end
        end
    end

    // Counter storage with asynchronous reset to RESET_VALUE.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < NUM_CNT; i++) begin
                cnt_q[i] <= RESET_VALUE;
            end
        end else begin
            for (int i = 0; i < NUM_CNT; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

`ifdef CSR_CNT_OVF_EN
    logic [NUM_CNT-1:0] wrap;
    logic [NUM_CNT-1:0] ovf_q;

    // A wrap is a real increment from all-ones; writing all-ones alone does not count.
    always_comb begin
        wrap = '0;
        for (int i = 0; i < NUM_CNT; i++) begin
            wrap[i] = inc_i[i] && !inhibit_i[i] && !mod_hit[i] && (&cnt_q[i]);
        end
    end

    // Sticky flags: a wrap in the same cycle as a clear keeps the flag set.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            ovf_q <= '0;
        end else begin
            ovf_q <= wrap | (ovf_q & ~ovf_clr_i);
        end
    end

    assign ovf_o     = ovf_q;
    assign ovf_irq_o = |ovf_q;
`endif

endmodule

// File: tb/tb_csr_counter_bank.sv
// Self-checking bench for csr_counter_bank (6 counters so that selects 6 and 7
// are out of range). Expected values come from a 64-bit array model of the
// counters plus fixed constants for the directed scenarios.
module tb_csr_counter_bank;

    localparam int N  = 6;
    localparam int SW = 3;

    logic          clk;
    logic          rst;
    logic          csr_en;
    logic [1:0]    csr_op;
    logic [SW-1:0] csr_sel;
    logic          csr_hi;
    logic [31:0]   wdata;
    logic [31:0]   rdata;
    logic [N-1:0]  inc;
    logic [N-1:0]  inh;
    logic [N-1:0]  ovf_clr;
`ifdef CSR_CNT_OVF_EN
    logic [N-1:0]  ovf;
    logic          irq;
`endif

    int checks;
    int failures;

    logic [63:0] m [N];
    logic [N-1:0] ovf_m;

    csr_counter_bank #(
        .NUM_CNT(N), .XLEN(32), .CNT_WIDTH(64), .RESET_VALUE(64'd0)
    ) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .csr_en_i    (csr_en),
        .csr_op_i    (csr_op),
        .csr_sel_i   (csr_sel),
        .csr_hi_i    (csr_hi),
        .csr_wdata_i (wdata),
        .inc_i       (inc),
        .inhibit_i   (inh),
`ifdef CSR_CNT_OVF_EN
        .ovf_clr_i   (ovf_clr),
        .ovf_o       (ovf),
        .ovf_irq_o   (irq),
`endif
        .csr_rdata_o (rdata)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Reference: apply one clock edge of the counter rules to the model.
    task automatic model_clk();
        logic [63:0] nm [N];
        logic [31:0] half;
        logic [31:0] res;
        logic [N-1:0] wr;
        wr = '0;
        for (int i = 0; i < N; i++) begin
            nm[i] = m[i];
            if (csr_en && csr_op != 2'b00 && int'(csr_sel) == i) begin
                half = csr_hi ? m[i][63:32] : m[i][31:0];
                case (csr_op)
                    2'b01:   res = wdata;
                    2'b10:   res = half | wdata;
                    default: res = half & ~wdata;
                endcase
                if (csr_hi) nm[i][63:32] = res;
                else        nm[i][31:0]  = res;
            end else if (inc[i] && !inh[i]) begin
                nm[i] = m[i] + 64'd1;
                wr[i] = (m[i] == 64'hFFFF_FFFF_FFFF_FFFF);
            end
        end
        ovf_m = wr | (ovf_m & ~ovf_clr);
        for (int i = 0; i < N; i++) m[i] = nm[i];
    endtask

    function automatic logic [31:0] exp_read(input int s, input bit h);
        if (s >= N) return 32'd0;
        return h ? m[s][63:32] : m[s][31:0];
    endfunction

    task automatic idle();
        csr_en = 1'b0; csr_op = 2'b00; csr_sel = '0; csr_hi = 1'b0;
        wdata = '0; inc = '0; inh = '0; ovf_clr = '0;
    endtask

    task automatic cyc();
        @(posedge clk);
        model_clk();
        @(negedge clk);
    endtask

    task automatic csr_wr(input int s, input bit h, input logic [1:0] op, input logic [31:0] d);
        csr_en = 1'b1; csr_op = op; csr_sel = SW'(s); csr_hi = h; wdata = d;
        cyc();
        idle();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        idle();
        for (int i = 0; i < N; i++) m[i] = 64'd0;
        ovf_m = '0;
        #2;
        for (int s = 0; s < 8; s++) begin
            for (int h = 0; h < 2; h++) begin
                csr_sel = SW'(s); csr_hi = h[0];
                #1;
                checks++;
                if (rdata !== 32'd0) begin
                    failures++;
                    $display("FAIL reset_read sel=%0d hi=%0d got=%h exp=0", s, h, rdata);
                end
            end
        end
`ifdef CSR_CNT_OVF_EN
        checks++;
        if (ovf !== '0 || irq !== 1'b0) begin
            failures++;
            $display("FAIL reset_ovf got=%b irq=%b exp=0", ovf, irq);
        end
`endif
        @(negedge clk);
        rst = 1'b0;
        idle();
    endtask

    task automatic test_inhibit();
        inc[0] = 1'b1;
        repeat (10) cyc();
        inh[0] = 1'b1;
        repeat (5) cyc();
        idle();
        #1;
        checks++;
        if (rdata !== 32'd10 || rdata !== exp_read(0, 0)) begin
            failures++;
            $display("FAIL inhibit_count got=%0d exp=10", rdata);
        end
    endtask

    task automatic test_carry();
        csr_wr(1, 0, 2'b01, 32'hFFFF_FFFF);
        inc[1] = 1'b1;
        cyc();
        idle();
        csr_sel = SW'(1); csr_hi = 1'b0;
        #1;
        checks++;
        if (rdata !== 32'h0) begin
            failures++;
            $display("FAIL carry_lo got=%h exp=00000000", rdata);
        end
        csr_hi = 1'b1;
        #1;
        checks++;
        if (rdata !== 32'h1) begin
            failures++;
            $display("FAIL carry_hi got=%h exp=00000001", rdata);
        end
    endtask

    task automatic test_set_clear();
        csr_wr(2, 0, 2'b01, 32'h0000_00F0);
        csr_en = 1'b1; csr_op = 2'b10; csr_sel = SW'(2); csr_hi = 1'b0; wdata = 32'h0F;
        #1;
        checks++;
        if (rdata !== 32'hF0) begin
            failures++;
            $display("FAIL premodify_read got=%h exp=000000f0", rdata);
        end
        cyc();
        idle();
        csr_sel = SW'(2);
        #1;
        checks++;
        if (rdata !== 32'hFF) begin
            failures++;
            $display("FAIL set_op got=%h exp=000000ff", rdata);
        end
        csr_wr(2, 0, 2'b11, 32'h11);
        csr_sel = SW'(2);
        #1;
        checks++;
        if (rdata !== 32'hEE) begin
            failures++;
            $display("FAIL clear_op got=%h exp=000000ee", rdata);
        end
        for (int s = 6; s < 8; s++) begin
            csr_en = 1'b1; csr_op = 2'b01; csr_sel = SW'(s); csr_hi = s[0]; wdata = 32'hDEAD_BEEF;
            #1;
            checks++;
            if (rdata !== 32'd0) begin
                failures++;
                $display("FAIL oor_read sel=%0d got=%h exp=0", s, rdata);
            end
            cyc();
        end
        idle();
        for (int s = 0; s < N; s++) begin
            for (int h = 0; h < 2; h++) begin
                csr_sel = SW'(s); csr_hi = h[0];
                #1;
                checks++;
                if (rdata !== exp_read(s, h[0])) begin
                    failures++;
                    $display("FAIL oor_nochange sel=%0d hi=%0d got=%h exp=%h", s, h, rdata, exp_read(s, h[0]));
                end
            end
        end
    endtask

    task automatic test_collision();
        csr_en = 1'b1; csr_op = 2'b01; csr_sel = SW'(3); csr_hi = 1'b0; wdata = 32'd5;
        inc = 6'b001001;
        cyc();
        idle();
        csr_sel = SW'(3);
        #1;
        checks++;
        if (rdata !== 32'd5) begin
            failures++;
            $display("FAIL collision_mod_wins got=%0d exp=5", rdata);
        end
        csr_sel = SW'(0);
        #1;
        checks++;
        if (rdata !== 32'd11) begin
            failures++;
            $display("FAIL collision_other_inc got=%0d exp=11", rdata);
        end
    endtask

    task automatic test_random();
        // Park every counter just below the wrap point so random traffic hits it.
        for (int s = 0; s < N; s++) begin
            csr_wr(s, 1, 2'b01, 32'hFFFF_FFFF);
            csr_wr(s, 0, 2'b01, 32'hFFFF_FFF8);
        end
        for (int k = 0; k < 600; k++) begin
            inc     = N'($urandom);
            inh     = N'($urandom & $urandom);
            ovf_clr = ($urandom_range(0, 7) == 0) ? N'($urandom) : '0;
            csr_en  = $urandom_range(0, 2) == 0;
            csr_op  = 2'($urandom);
            csr_sel = SW'($urandom);
            csr_hi  = 1'($urandom);
            wdata   = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFF : $urandom;
            #1;
            checks++;
            if (rdata !== exp_read(int'(csr_sel), csr_hi)) begin
                failures++;
                $display("FAIL random_read iter=%0d sel=%0d hi=%0d got=%h exp=%h",
                         k, csr_sel, csr_hi, rdata, exp_read(int'(csr_sel), csr_hi));
            end
`ifdef CSR_CNT_OVF_EN
            checks++;
            if (ovf !== ovf_m || irq !== (|ovf_m)) begin
                failures++;
                $display("FAIL random_ovf iter=%0d got=%b irq=%b exp=%b", k, ovf, irq, ovf_m);
            end
`endif
            cyc();
        end
        idle();
        for (int s = 0; s < N; s++) begin
            for (int h = 0; h < 2; h++) begin
                csr_sel = SW'(s); csr_hi = h[0];
                #1;
                checks++;
                if (rdata !== exp_read(s, h[0])) begin
                    failures++;
                    $display("FAIL random_final sel=%0d hi=%0d got=%h exp=%h", s, h, rdata, exp_read(s, h[0]));
                end
            end
        end
    endtask

    task automatic test_reset_mid();
        inc = '1;
        repeat (3) cyc();
        csr_en = 1'b1; csr_op = 2'b01; csr_sel = SW'(4); wdata = 32'h1234_5678;
        #2;
        rst = 1'b1;
        for (int i = 0; i < N; i++) m[i] = 64'd0;
        ovf_m = '0;
        #1;
        for (int s = 0; s < N; s++) begin
            csr_sel = SW'(s); csr_hi = 1'b0;
            #0.1;
            checks++;
            if (rdata !== 32'd0) begin
                failures++;
                $display("FAIL reset_async sel=%0d got=%h exp=0", s, rdata);
            end
        end
`ifdef CSR_CNT_OVF_EN
        checks++;
        if (ovf !== '0) begin
            failures++;
            $display("FAIL reset_async_ovf got=%b exp=0", ovf);
        end
`endif
        @(negedge clk);
        rst = 1'b0;
        idle();
        for (int s = 0; s < N; s++) begin
            csr_sel = SW'(s); csr_hi = 1'b1;
            #1;
            checks++;
            if (rdata !== 32'd0) begin
                failures++;
                $display("FAIL reset_hi_clear sel=%0d got=%h exp=0", s, rdata);
            end
        end
    endtask

`ifdef CSR_CNT_OVF_EN
    task automatic test_ovf();
        ovf_clr = '1;
        cyc();
        idle();
        csr_wr(0, 1, 2'b01, 32'hFFFF_FFFF);
        csr_wr(0, 0, 2'b01, 32'hFFFF_FFFF);
        #1;
        checks++;
        if (ovf[0] !== 1'b0) begin
            failures++;
            $display("FAIL ovf_write_ones got=%b exp=0", ovf[0]);
        end
        inc[0] = 1'b1;
        cyc();
        idle();
        csr_sel = SW'(0);
        #1;
        checks++;
        if (rdata !== 32'd0 || ovf[0] !== 1'b1 || irq !== 1'b1) begin
            failures++;
            $display("FAIL ovf_wrap rdata=%h ovf=%b irq=%b exp 0/1/1", rdata, ovf[0], irq);
        end
        ovf_clr[0] = 1'b1;
        cyc();
        idle();
        #1;
        checks++;
        if (ovf[0] !== 1'b0 || irq !== 1'b0) begin
            failures++;
            $display("FAIL ovf_clear ovf=%b irq=%b exp 0/0", ovf[0], irq);
        end
        csr_wr(0, 1, 2'b01, 32'hFFFF_FFFF);
        csr_wr(0, 0, 2'b01, 32'hFFFF_FFFF);
        inc[0] = 1'b1; ovf_clr[0] = 1'b1;
        cyc();
        idle();
        #1;
        checks++;
        if (ovf[0] !== 1'b1 || irq !== 1'b1) begin
            failures++;
            $display("FAIL ovf_set_wins ovf=%b irq=%b exp 1/1", ovf[0], irq);
        end
    endtask
`endif

    initial begin
        checks = 0;
        failures = 0;
        test_reset();
        test_inhibit();
        test_carry();
        test_set_clear();
        test_collision();
        test_random();
        test_reset_mid();
`ifdef CSR_CNT_OVF_EN
        test_ovf();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
